// File: rtl/s2a_sample_packer.sv
// Packs I/Q ADC samples (or a test ramp) into 32-bit stream-buffer words, one Ien per word.
// Also keeps a word counter and a sticky full-scale flag for software.
module s2a_sample_packer #(
    parameter int DW = 12
) (
    input  logic          Sclk,
    input  logic          rst,
    input  logic          sync,
    input  logic          en,
    input  logic          mode,
    input  logic          test_en,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_i,
    input  logic [DW-1:0] adc_q,
    output logic          Ien,
    output logic [31:0]   Idata,
    output logic [31:0]   word_cnt,
    output logic          sat_flag,
    output logic          mode_q
);

    typedef enum logic {PAIR_EMPTY, PAIR_HALF} pair_t;

    localparam logic [DW-1:0] POS_FS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_FS = {1'b1, {(DW-1){1'b0}}};

    pair_t         pair_q, pair_d;
    logic          test_q;
    logic [DW-1:0] ramp;
    logic [15:0]   hold;
    logic          accept, word_done, sample_sat;
    logic [DW-1:0] sel_i, sel_q;
    logic [7:0]    i8, q8;
    logic [31:0]   word_d;

    always_comb begin
        accept = adc_valid & en & ~sync & ~rst;
        if (test_q) begin
            sel_i = ramp;
            sel_q = ~ramp;
        end else begin
            sel_i = adc_i;
            sel_q = adc_q;
        end
        sample_sat = (sel_i == POS_FS) | (sel_i == NEG_FS) |
                     (sel_q == POS_FS) | (sel_q == NEG_FS);
        i8 = sel_i[DW-1 -: 8];
        q8 = sel_q[DW-1 -: 8];
        word_done = accept & (~mode_q | (pair_q == PAIR_HALF));
        if (mode_q)
            word_d = {q8, i8, hold};
        else
            word_d = {16'($signed(sel_q)), 16'($signed(sel_i))};
    end

    // Pair tracker for two-samples-per-word mode; sync/rst drop a half-built word.
    always_comb begin
        pair_d = pair_q;
        if (rst | sync)
            pair_d = PAIR_EMPTY;
        else if (accept & mode_q) begin
            if (pair_q == PAIR_EMPTY)
                pair_d = PAIR_HALF;
            else
                pair_d = PAIR_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge Sclk) begin
        pair_q <= pair_d;
    end

    always_ff @(posedge Sclk) begin
        if (rst | sync) begin
            Ien      <= 1'b0;
            Idata    <= '0;
            word_cnt <= '0;
            ramp     <= '0;
            mode_q   <= mode;
            test_q   <= test_en;
            if (rst)
                sat_flag <= 1'b0;
        end else begin
            Ien <= word_done;
            if (word_done) begin
                Idata    <= word_d;
                word_cnt <= word_cnt + 32'd1;
            end
            if (accept) begin
                ramp <= ramp + 1'b1;
                if (sample_sat)
                    sat_flag <= 1'b1;
            end
        end
    end

    // NOTE: hold is pure datapath with no reset; it is only read while pair_q is PAIR_HALF.
    always_ff @(posedge Sclk) begin
        if (accept && mode_q && pair_q == PAIR_EMPTY)
            hold <= {q8, i8};
    end

endmodule

// File: doc/s2a_sample_packer.md
Name: s2a_sample_packer

Overview:
- Sclk-domain stage directly upstream of the stream-to-AXI controller.
- Takes complex ADC samples (I/Q, DW bits each), optionally substitutes a test ramp, and packs them into 32-bit words.
- Drives the write strobe and write data of the 32-word stream buffer. The downstream controller derives the buffer address from its own count of strobes, so this block issues exactly one Ien pulse per completed word.
- Also provides a word counter and a sticky saturation flag for software.

Parameters:
- DW, 12, ADC sample width per rail (I or Q); legal range 8..16.

Ports:
- Sclk  input  1  stream clock
- rst  input  1  synchronous reset, active-high
- sync  input  1  system sync; synchronous clear, same cycle semantics as rst except sat_flag is held
- en  input  1  capture enable; samples arriving while low are ignored
- mode  input  1  packing mode request; 0 = one sample/word, 1 = two samples/word; latched only on rst/sync
- test_en  input  1  1 = replace ADC data with ramp pattern; latched only on rst/sync
- adc_valid  input  1  sample strobe
- adc_i  input  DW  in-phase sample, two's complement
- adc_q  input  DW  quadrature sample, two's complement
- Ien  output  1  buffer write strobe, one cycle per packed word
- Idata  output  32  packed word, valid when Ien=1
- word_cnt  output  32  words emitted since rst/sync, wraps 0xFFFFFFFF->0
- sat_flag  output  1  sticky: some accepted sample hit full scale; cleared only by rst
- mode_q  output  1  currently active (latched) mode

Behaviour:
- Reset (rst=1 at Sclk edge): Ien=0, Idata=0, word_cnt=0, sat_flag=0, ramp=0, half=0. mode_q<=mode, test_q<=test_en.
- sync=1 (rst=0): same clears as reset except sat_flag is held. Any half-packed word is discarded. mode_q and test_q are re-latched.
- rst/sync dominate adc_valid in the same cycle; that sample is dropped.
- Accept condition: adc_valid & en & ~sync & ~rst.
- Source select per accepted sample:
  - test_q=0: (I,Q) = (adc_i, adc_q).
  - test_q=1: I = ramp[DW-1:0], Q = ~ramp[DW-1:0]; ramp increments by 1 per accepted sample, DW-bit wrap.
- Saturation: an accepted sample with I or Q equal to +2^(DW-1)-1 or -2^(DW-1) sets sat_flag the next cycle. Evaluated on the selected source, so the ramp also triggers it.
- Mode 0: each accepted sample produces one word, Idata = {sext16(Q), sext16(I)}. For DW<16 this is sign extension; for DW=16 no extension.
- Mode 1:
  - Each rail is reduced to its top 8 bits, I8 = I[DW-1:DW-8].
  - The first accepted sample is stored in a holding register and half<=1; there is no Ien.
  - The second produces Idata = {Q8_1, I8_1, Q8_0, I8_0} (sample 0 in the low half), and half<=0.
- Latency: Ien and Idata are registered, asserted the cycle after the accept that completes a word. Ien is never high for two words in one cycle; back-to-back accepts give back-to-back Ien.
- word_cnt increments in the same cycle Ien is asserted (the value read alongside Ien already includes that word).
- en dropping mid-pair in mode 1 keeps the held half. The pair completes on the next accepted sample after en returns. Only sync/rst discard it.
- Idata holds its last value while Ien=0.
- Changing mode or test_en without sync has no effect on mode_q or output format.

Test Plan:
- Mode 0, DW=12, test_en=0: after rst, send (I,Q) = (0x123, 0xF00) -> one cycle later Ien=1, Idata=0xFF000123, word_cnt=1.
- Mode 1 pair: send (0x7F0, 0x810) then (0x010, 0xFF0) -> no Ien after the first; one cycle after the second, Idata=0xFF0181_7F (bytes Q1=0xFF, I1=0x01, Q0=0x81, I0=0x7F), i.e. 0xFF01817F, and sat_flag stays 0.
- Saturation: sample I=0x7FF -> sat_flag=1 the next cycle. Pulse sync -> sat_flag stays 1 and word_cnt=0. Pulse rst -> sat_flag=0.
- Mid-pair sync, mode 1: one sample, then sync, then two samples -> exactly one Ien, containing only the two post-sync samples.
- Test ramp: sync with test_en=1, mode=0, then 3 valids -> Idata sequence 0xFFFF0000, 0xFFFE0001, 0xFFFD0002 (Q = ~ramp sign-extended); rst/sync resets the ramp to 0.
- Gating and simultaneity: valid with en=0 -> no Ien, ramp frozen. valid coincident with sync -> sample dropped, word_cnt=0. Mode toggled without sync -> format unchanged and mode_q unchanged.
